// File: rtl/alu.sv
`default_nettype none
// ============================================================================
// Module   : alu
// Purpose  : Signed two's-complement arithmetic unit. It performs add,
//            subtract, multiply or divide, selected by a 2-bit opcode. The
//            result and the overflow flag are registered, so the latency is
//            one cycle, and a new operation can be issued on every cycle.
// Ports    : clk      - rising-edge clock
//            rst_n    - synchronous reset, active-low
//            ina      - operand A, signed [WIDTH-1:0]
//            inb      - operand B, signed [WIDTH-1:0]
//            sel      - opcode: 00 add, 01 sub, 10 mul, 11 div
//            out      - registered result, signed [WIDTH-1:0]
//            overflow - registered flag: result not representable, or an
//                       illegal division (divide by zero, MIN / -1)
// Revision : 1.0 - initial release
// ============================================================================
module alu #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] ina,
  input  logic [WIDTH-1:0] inb,
  input  logic [1:0]       sel,
  output logic [WIDTH-1:0] out,
  output logic             overflow
);

  localparam logic [1:0]       OP_ADD  = 2'b00;
  localparam logic [1:0]       OP_SUB  = 2'b01;
  localparam logic [1:0]       OP_MUL  = 2'b10;
  localparam logic [1:0]       OP_DIV  = 2'b11;
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] ONE     = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0]          sum_w;
  logic [WIDTH-1:0]          diff_w;
  logic signed [2*WIDTH-1:0] a_ext_w;
  logic signed [2*WIDTH-1:0] b_ext_w;
  logic signed [2*WIDTH-1:0] prod_w;
  logic [WIDTH:0]            prod_top_w;
  logic                      div_zero_w;
  logic                      div_ovf_w;
  logic signed [WIDTH-1:0]   divisor_w;
  logic signed [WIDTH-1:0]   quot_w;

  logic [WIDTH-1:0]          out_d,  out_q;
  logic                      ovf_d,  ovf_q;

  assign sum_w  = ina + inb;
  assign diff_w = ina - inb;

  // Both operands are sign-extended to the full product width. The multiply
  // is then exact, and its low 2*WIDTH bits are the true signed product.
  assign a_ext_w = {{WIDTH{ina[WIDTH-1]}}, ina};
  assign b_ext_w = {{WIDTH{inb[WIDTH-1]}}, inb};
  assign prod_w  = a_ext_w * b_ext_w;

  // The product fits in WIDTH bits only when the top WIDTH+1 bits are all
  // equal.
  assign prod_top_w = prod_w[2*WIDTH-1:WIDTH-1];

  // Two divides are illegal: B = 0, and MIN / -1. For these the divisor is
  // forced to 1, so the divide operator never sees an illegal operand pair.
  // The result itself is then chosen separately below.
  assign div_zero_w = (inb == '0);
  assign div_ovf_w  = (ina == MIN_NEG) && (&inb);
  assign divisor_w  = (div_zero_w || div_ovf_w) ? $signed(ONE) : $signed(inb);
  assign quot_w     = $signed(ina) / divisor_w;

  always_comb begin
    out_d = '0;
    ovf_d = 1'b0;
    case (sel)
      OP_ADD: begin
        out_d = sum_w;
        ovf_d = (ina[WIDTH-1] == inb[WIDTH-1]) &&
                (sum_w[WIDTH-1] != ina[WIDTH-1]);
      end
      OP_SUB: begin
        out_d = diff_w;
        ovf_d = (ina[WIDTH-1] != inb[WIDTH-1]) &&
                (diff_w[WIDTH-1] != ina[WIDTH-1]);
      end
      OP_MUL: begin
        out_d = prod_w[WIDTH-1:0];
        ovf_d = !((&prod_top_w) || !(|prod_top_w));
      end
      OP_DIV: begin
        if (div_zero_w) begin
          out_d = '0;
          ovf_d = 1'b1;
        end else begin
          // For MIN / -1 the forced divisor of 1 returns A, which is MIN.
          out_d = quot_w;
          ovf_d = div_ovf_w;
        end
      end
      default: begin
        out_d = '0;
        ovf_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      out_q <= out_d;
      ovf_q <= ovf_d;
    end
  end

  assign out      = out_q;
  assign overflow = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_alu.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu
// Purpose  : Directed testbench for alu. Each operation is issued on a
//            negative clock edge and checked 1 ns after the following rising
//            edge. Expected values are hand-computed constants or, for the
//            back-to-back sweep, come from a wide-integer reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu;

  logic        clk;
  logic        rst_n;
  logic [15:0] ina;
  logic [15:0] inb;
  logic [1:0]  sel;
  logic [15:0] out;
  logic        overflow;

  int n_assert = 0;
  int n_fail   = 0;

  alu #(.WIDTH(16)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ina      (ina),
    .inb      (inb),
    .sel      (sel),
    .out      (out),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] eo, input logic eov);
    n_assert++;
    assert (out === eo) else begin
      n_fail++;
      $error("FAIL %s: out=%h expected %h", tag, out, eo);
    end
    n_assert++;
    assert (overflow === eov) else begin
      n_fail++;
      $error("FAIL %s: overflow=%b expected %b", tag, overflow, eov);
    end
  endtask

  // Drive one operation, then sample once the next rising edge has passed.
  task automatic step(input logic [15:0] a, input logic [15:0] b, input logic [1:0] s);
    @(negedge clk);
    ina = a;
    inb = b;
    sel = s;
    @(posedge clk);
    #1;
  endtask

  // Reference model built on wide integers. An overflow is any result that
  // lies outside the 16-bit signed range.
  task automatic model(input logic [15:0] a, input logic [15:0] b, input logic [1:0] s,
                       output logic [15:0] eo, output logic eov);
    longint sa, sb, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    r  = 0;
    eov = 1'b0;
    case (s)
      2'b00: r = sa + sb;
      2'b01: r = sa - sb;
      2'b10: r = sa * sb;
      default: begin
        if (sb == 0) begin
          r   = 0;
          eov = 1'b1;
        end else begin
          r = sa / sb;
        end
      end
    endcase
    if (r > 32767 || r < -32768) eov = 1'b1;
    eo = r[15:0];
  endtask

  initial begin
    logic [15:0] a, b, eo;
    logic        eov;
    logic [1:0]  s;

    rst_n = 1'b0;
    ina   = 16'h1234;
    inb   = 16'h0001;
    sel   = 2'b00;

    // Reset holds for two edges, even though a legal add is presented.
    @(posedge clk); #1;
    check("reset_edge1", 16'h0000, 1'b0);
    @(posedge clk); #1;
    check("reset_edge2", 16'h0000, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("reset_release", 16'h1235, 1'b0);

    step(16'h0012, 16'h0034, 2'b00); check("add_small",    16'h0046, 1'b0);
    step(16'h7FFF, 16'h0001, 2'b00); check("add_pos_ovf",  16'h8000, 1'b1);
    step(16'h8000, 16'h7FFF, 2'b00); check("add_mixed",    16'hFFFF, 1'b0);
    step(16'h8000, 16'h8000, 2'b00); check("add_neg_ovf",  16'h0000, 1'b1);

    step(16'h4100, 16'h0100, 2'b01); check("sub_pos",      16'h4000, 1'b0);
    step(16'h0100, 16'h4000, 2'b01); check("sub_neg_res",  16'hC100, 1'b0);
    step(16'h8000, 16'h0001, 2'b01); check("sub_ovf",      16'h7FFF, 1'b1);
    step(16'h7FFF, 16'hFFFF, 2'b01); check("sub_pos_ovf",  16'h8000, 1'b1);

    step(16'h00C8, 16'h0064, 2'b10); check("mul_small",    16'h4E20, 1'b0);
    step(16'h7FFF, 16'h0002, 2'b10); check("mul_ovf",      16'hFFFE, 1'b1);
    step(16'h0000, 16'h1234, 2'b10); check("mul_zero",     16'h0000, 1'b0);
    step(16'hFFFE, 16'h0003, 2'b10); check("mul_neg",      16'hFFFA, 1'b0);
    step(16'h8000, 16'h0001, 2'b10); check("mul_min_one",  16'h8000, 1'b0);
    step(16'h8000, 16'hFFFF, 2'b10); check("mul_min_neg1", 16'h8000, 1'b1);

    step(16'h4E21, 16'h0064, 2'b11); check("div_trunc",    16'h00C8, 1'b0);
    step(16'h0005, 16'h4000, 2'b11); check("div_small",    16'h0000, 1'b0);
    step(16'hFFF9, 16'h0002, 2'b11); check("div_neg",      16'hFFFD, 1'b0);
    step(16'h1234, 16'h0000, 2'b11); check("div_zero",     16'h0000, 1'b1);
    step(16'h8000, 16'hFFFF, 2'b11); check("div_min_neg1", 16'h8000, 1'b1);
    step(16'h0007, 16'hFFFE, 2'b11); check("div_pos_neg",  16'hFFFD, 1'b0);

    // The outputs must hold through the falling edge, with no new edge.
    @(negedge clk);
    check("hold_negedge", 16'h0000 - 16'h0003, 1'b0);

    // Reset wins over an operation that is in progress.
    ina   = 16'h7FFF;
    inb   = 16'h0001;
    sel   = 2'b00;
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("reset_priority", 16'h0000, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // Back-to-back: the opcode rotates and the operands change every cycle.
    // Some cycles use the corner operands so that illegal or overflowing
    // cases also appear in the sweep.
    for (int i = 0; i < 64; i++) begin
      s = i[1:0];
      a = 16'($urandom);
      b = 16'($urandom);
      if (i % 16 == 3)  b = 16'h0000;
      if (i % 16 == 7)  begin a = 16'h8000; b = 16'hFFFF; end
      if (i % 16 == 10) b = 16'h0000;
      model(a, b, s, eo, eov);
      step(a, b, s);
      check($sformatf("b2b_%0d_op%0d", i, s), eo, eov);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  // Overall time guard: if the run stalls, it ends with a FAIL line.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, required completion");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
